wb_stage: RTL and testbench

Registered MEM/WB pipeline stage with writeback select and architectural HI/LO ownership, for the 54-instruction pipelined MIPS CPU. Accepts one instruction per cycle from MEM through a valid/ready handshake and stalls on an unfinished multi-cycle divide. Drives the register-file write port and a forwarding tap, and holds HI/LO internally so MFHI/MFLO read committed values. Adds flush, backpressure, parametrised width and retire/stall counters.

---
 rtl/wb_pkg.sv | 44 ++++
 rtl/wb_hilo.sv | 80 ++++++++
 rtl/wb_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings for the MEM/WB writeback stage: rd
//               writeback source selects, HI/LO source selects, stage
//               state enum and the "needs divider" helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // rd writeback source select
    localparam logic [2:0] RD_LO    = 3'd0;
    localparam logic [2:0] RD_NPC   = 3'd1;
    localparam logic [2:0] RD_CLZ   = 3'd2;
    localparam logic [2:0] RD_CP0   = 3'd3;
    localparam logic [2:0] RD_DMEM  = 3'd4;
    localparam logic [2:0] RD_ALU   = 3'd5;
    localparam logic [2:0] RD_HI    = 3'd6;
    localparam logic [2:0] RD_MULLO = 3'd7;

    // HI / LO source select
    localparam logic [1:0] HL_DIV  = 2'd0;
    localparam logic [1:0] HL_MUL  = 2'd1;
    localparam logic [1:0] HL_RS   = 2'd2;
    localparam logic [1:0] HL_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_WAIT_DIV = 2'd2
    } wb_state_e;

    // An instruction depends on the divider when it writes HI or LO from it.
    function automatic logic needs_div(
        input logic       hi_wena,
        input logic [1:0] hi_sel,
        input logic       lo_wena,
        input logic [1:0] lo_sel
    );
        return (hi_wena && (hi_sel == HL_DIV)) || (lo_wena && (lo_sel == HL_DIV));
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_hilo.sv
`default_nettype none
// ============================================================================
// Module      : wb_hilo
// Description : Architectural HI/LO registers with their source muxes.
//               Updated only on a commit of an instruction that writes them.
// Ports       : clk, rst           - clock, sync active-high reset
//               commit             - held instruction retires this cycle
//               hi_wena/lo_wena    - instruction writes HI / LO
//               hi_sel/lo_sel      - source: divider, multiplier, rs, none
//               rs_data, mul_hi, mul_lo, div_r, div_q - candidate sources
//               hi_q, lo_q         - committed HI / LO
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hilo
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic              hi_wena,
    input  logic              lo_wena,
    input  logic [1:0]        hi_sel,
    input  logic [1:0]        lo_sel,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    input  logic [DATA_W-1:0] div_r,
    input  logic [DATA_W-1:0] div_q,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] w_hi_src;
    logic [DATA_W-1:0] w_lo_src;

    // Divider: remainder goes to HI, quotient to LO.
    // HL_NONE recirculates the current value so a reserved code is a no-op.
    always_comb begin
        w_hi_src = r_hi;
        case (hi_sel)
            HL_DIV:  w_hi_src = div_r;
            HL_MUL:  w_hi_src = mul_hi;
            HL_RS:   w_hi_src = rs_data;
            default: w_hi_src = r_hi;
        endcase
    end

    always_comb begin
        w_lo_src = r_lo;
        case (lo_sel)
            HL_DIV:  w_lo_src = div_q;
            HL_MUL:  w_lo_src = mul_lo;
            HL_RS:   w_lo_src = rs_data;
            default: w_lo_src = r_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (commit && hi_wena) begin
                r_hi <= w_hi_src;
            end
            if (commit && lo_wena) begin
                r_lo <= w_lo_src;
            end
        end
    end

    assign hi_q = r_hi;
    assign lo_q = r_lo;

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Registered MEM/WB pipeline stage. Accepts one instruction
//               per cycle over valid/ready, holds it until it can retire
//               (waiting on the divider when it needs divide results),
//               drives the register-file write port and owns HI/LO.
// Ports       : clk, rst                 - clock, sync active-high reset
//               in_valid / in_ready      - MEM handshake
//               flush                    - drop held and incoming instruction
//               npc..dmem_data           - rd result sources
//               rd_sel/rd_waddr/rd_wena  - rd writeback control
//               hi_*/lo_*                - HI/LO write control
//               div_r/div_q/div_done     - divider results
//               div_abort                - held divide was flushed
//               rf_we/rf_waddr/rf_wdata  - register-file write port
//               hi_q/lo_q                - committed HI/LO
//               retire_cnt/stall_cnt     - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [DATA_W-1:0]  npc,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  cp0_data,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic [DATA_W-1:0]  clz_data,
    input  logic [DATA_W-1:0]  mul_hi,
    input  logic [DATA_W-1:0]  mul_lo,
    input  logic [DATA_W-1:0]  dmem_data,
    input  logic [2:0]         rd_sel,
    input  logic [RADDR_W-1:0] rd_waddr,
    input  logic               rd_wena,
    input  logic [1:0]         hi_sel,
    input  logic [1:0]         lo_sel,
    input  logic               hi_wena,
    input  logic               lo_wena,
    input  logic [DATA_W-1:0]  div_r,
    input  logic [DATA_W-1:0]  div_q,
    input  logic               div_done,
    output logic               div_abort,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [DATA_W-1:0]  hi_q,
    output logic [DATA_W-1:0]  lo_q,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    wb_state_e          r_state;
    wb_state_e          w_state_nxt;

    logic [DATA_W-1:0]  r_npc;
    logic [DATA_W-1:0]  r_rs_data;
    logic [DATA_W-1:0]  r_cp0_data;
    logic [DATA_W-1:0]  r_alu_data;
    logic [DATA_W-1:0]  r_clz_data;
    logic [DATA_W-1:0]  r_mul_hi;
    logic [DATA_W-1:0]  r_mul_lo;
    logic [DATA_W-1:0]  r_dmem_data;
    logic [2:0]         r_rd_sel;
    logic [RADDR_W-1:0] r_rd_waddr;
    logic               r_rd_wena;
    logic [1:0]         r_hi_sel;
    logic [1:0]         r_lo_sel;
    logic               r_hi_wena;
    logic               r_lo_wena;

    logic [CNT_W-1:0]   r_retire_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_occupied;
    logic               w_need_div;
    logic               w_in_need_div;
    logic               w_commit_raw;
    logic               w_commit;
    logic               w_accept;
    logic               w_div_wait;

    assign w_occupied    = (r_state != ST_EMPTY);
    assign w_need_div    = needs_div(r_hi_wena, r_hi_sel, r_lo_wena, r_lo_sel);
    assign w_in_need_div = needs_div(hi_wena, hi_sel, lo_wena, lo_sel);

    // The held instruction is able to retire; flush then vetoes the actual
    // commit, but in_ready is already forced low by flush itself.
    assign w_commit_raw  = w_occupied && !(w_need_div && !div_done);
    assign w_commit      = w_commit_raw && !flush;
    assign in_ready      = (!w_occupied || w_commit_raw) && !flush;
    assign w_accept      = in_valid && in_ready;
    assign w_div_wait    = (r_state == ST_WAIT_DIV) && !div_done;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        div_abort   = 1'b0;
        case (r_state)
            ST_EMPTY, ST_FULL, ST_WAIT_DIV: w_state_nxt = r_state;
            default:                        w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            div_abort   = w_div_wait;
        end else if (w_accept) begin
            w_state_nxt = w_in_need_div ? ST_WAIT_DIV : ST_FULL;
        end else if (w_commit) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_npc       <= '0;
            r_rs_data   <= '0;
            r_cp0_data  <= '0;
            r_alu_data  <= '0;
            r_clz_data  <= '0;
            r_mul_hi    <= '0;
            r_mul_lo    <= '0;
            r_dmem_data <= '0;
            r_rd_sel    <= RD_LO;
            r_rd_waddr  <= '0;
            r_rd_wena   <= 1'b0;
            r_hi_sel    <= HL_NONE;
            r_lo_sel    <= HL_NONE;
            r_hi_wena   <= 1'b0;
            r_lo_wena   <= 1'b0;
        end else if (w_accept) begin
            r_npc       <= npc;
            r_rs_data   <= rs_data;
            r_cp0_data  <= cp0_data;
            r_alu_data  <= alu_data;
            r_clz_data  <= clz_data;
            r_mul_hi    <= mul_hi;
            r_mul_lo    <= mul_lo;
            r_dmem_data <= dmem_data;
            r_rd_sel    <= rd_sel;
            r_rd_waddr  <= rd_waddr;
            r_rd_wena   <= rd_wena;
            r_hi_sel    <= hi_sel;
            r_lo_sel    <= lo_sel;
            r_hi_wena   <= hi_wena;
            r_lo_wena   <= lo_wena;
        end
    end

    // ------------------------------------------------------------------
    // HI / LO ownership
    // ------------------------------------------------------------------
    wb_hilo #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .commit  (w_commit),
        .hi_wena (r_hi_wena),
        .lo_wena (r_lo_wena),
        .hi_sel  (r_hi_sel),
        .lo_sel  (r_lo_sel),
        .rs_data (r_rs_data),
        .mul_hi  (r_mul_hi),
        .mul_lo  (r_mul_lo),
        .div_r   (div_r),
        .div_q   (div_q),
        .hi_q    (hi_q),
        .lo_q    (lo_q)
    );

    // ------------------------------------------------------------------
    // Register-file write port. MFHI/MFLO read the committed registers so
    // a preceding MTHI/MTLO that retired last cycle is already visible.
    // ------------------------------------------------------------------
    always_comb begin
        rf_wdata = lo_q;
        case (r_rd_sel)
            RD_LO:    rf_wdata = lo_q;
            RD_NPC:   rf_wdata = r_npc;
            RD_CLZ:   rf_wdata = r_clz_data;
            RD_CP0:   rf_wdata = r_cp0_data;
            RD_DMEM:  rf_wdata = r_dmem_data;
            RD_ALU:   rf_wdata = r_alu_data;
            RD_HI:    rf_wdata = hi_q;
            RD_MULLO: rf_wdata = r_mul_lo;
            default:  rf_wdata = lo_q;
        endcase
    end

    assign rf_we    = w_commit && r_rd_wena && (r_rd_waddr != '0);
    assign rf_waddr = r_rd_waddr;

    // ------------------------------------------------------------------
    // Performance counters (wrap naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_commit) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
            if (w_div_wait) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage. A transaction-level model
//               tracks the held instruction and architectural HI/LO and
//               pushes one expected-output record per cycle; a monitor pops
//               and compares at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    import wb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, in_ready, flush;
    logic [DATA_W-1:0]  npc, rs_data, cp0_data, alu_data, clz_data;
    logic [DATA_W-1:0]  mul_hi, mul_lo, dmem_data;
    logic [2:0]         rd_sel;
    logic [RADDR_W-1:0] rd_waddr;
    logic               rd_wena;
    logic [1:0]         hi_sel, lo_sel;
    logic               hi_wena, lo_wena;
    logic [DATA_W-1:0]  div_r, div_q;
    logic               div_done, div_abort;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata, hi_q, lo_q;
    logic [CNT_W-1:0]   retire_cnt, stall_cnt;

    wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .npc(npc), .rs_data(rs_data), .cp0_data(cp0_data),
        .alu_data(alu_data), .clz_data(clz_data), .mul_hi(mul_hi),
        .mul_lo(mul_lo), .dmem_data(dmem_data), .rd_sel(rd_sel),
        .rd_waddr(rd_waddr), .rd_wena(rd_wena), .hi_sel(hi_sel),
        .lo_sel(lo_sel), .hi_wena(hi_wena), .lo_wena(lo_wena),
        .div_r(div_r), .div_q(div_q), .div_done(div_done),
        .div_abort(div_abort), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] npc, rs, cp0, alu, clz, mhi, mlo, dmem;
        logic [2:0]  rd_sel;
        logic [4:0]  waddr;
        logic        wena;
        logic [1:0]  hsel, lsel;
        logic        hwe, lwe;
        int          dwait;
        logic [31:0] dq, dr;
    } instr_t;

    typedef struct {
        logic        ready, abort, we;
        logic [4:0]  waddr;
        logic [31:0] wdata, hi, lo, ret, stl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   en_check = 1'b0;

    // Reference model: what is architecturally held/committed
    bit          m_held;
    instr_t      m_cur;
    int          m_wait;
    logic [31:0] m_hi, m_lo, m_ret, m_stl;

    function automatic instr_t zero_instr();
        instr_t z;
        z = '{default: '0};
        return z;
    endfunction

    function automatic bit is_div(instr_t i);
        return (i.hwe && i.hsel == 2'd0) || (i.lwe && i.lsel == 2'd0);
    endfunction

    function automatic logic [31:0] wb_value(instr_t i);
        case (i.rd_sel)
            3'd0: return m_lo;
            3'd1: return i.npc;
            3'd2: return i.clz;
            3'd3: return i.cp0;
            3'd4: return i.dmem;
            3'd5: return i.alu;
            3'd6: return m_hi;
            default: return i.mlo;
        endcase
    endfunction

    function automatic instr_t rand_instr(bit allow_div);
        instr_t i;
        i.npc = $urandom; i.rs = $urandom; i.cp0 = $urandom; i.alu = $urandom;
        i.clz = $urandom; i.mhi = $urandom; i.mlo = $urandom; i.dmem = $urandom;
        i.rd_sel = 3'($urandom_range(0, 7));
        i.waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        i.wena   = 1'($urandom);
        i.hsel   = 2'($urandom_range(0, 3));
        i.lsel   = 2'($urandom_range(0, 3));
        i.hwe    = ($urandom_range(0, 2) == 0);
        i.lwe    = ($urandom_range(0, 2) == 0);
        if (!allow_div) begin
            if (i.hsel == 2'd0) i.hsel = 2'd1;
            if (i.lsel == 2'd0) i.lsel = 2'd2;
        end
        i.dwait = $urandom_range(0, 4);
        i.dq = $urandom; i.dr = $urandom;
        return i;
    endfunction

    task automatic model_reset();
        m_held = 1'b0; m_cur = zero_instr(); m_wait = 0;
        m_hi = '0; m_lo = '0; m_ret = '0; m_stl = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    endtask

    // One clock of stimulus; returns whether the instruction was accepted.
    task automatic cycle(input bit v, input instr_t ins, input bit fl, input bit r, output bit acc);
        exp_t e;
        bit   hd, done, can_commit, commit;
        @(posedge clk); #1;
        rst = r; flush = fl; in_valid = v;
        npc = ins.npc; rs_data = ins.rs; cp0_data = ins.cp0; alu_data = ins.alu;
        clz_data = ins.clz; mul_hi = ins.mhi; mul_lo = ins.mlo; dmem_data = ins.dmem;
        rd_sel = ins.rd_sel; rd_waddr = ins.waddr; rd_wena = ins.wena;
        hi_sel = ins.hsel; lo_sel = ins.lsel; hi_wena = ins.hwe; lo_wena = ins.lwe;
        hd   = m_held && is_div(m_cur);
        done = hd && (m_wait == 0);
        if (hd) begin
            div_q = m_cur.dq; div_r = m_cur.dr; div_done = done;
        end else begin
            div_q = $urandom; div_r = $urandom; div_done = 1'($urandom);
        end
        can_commit = m_held && (!is_div(m_cur) || done);
        commit     = can_commit && !fl;
        e.ready = (!m_held || can_commit) && !fl;
        e.abort = fl && hd && !done;
        e.we    = commit && m_cur.wena && (m_cur.waddr != 5'd0);
        e.waddr = m_cur.waddr;
        e.wdata = wb_value(m_cur);
        e.hi = m_hi; e.lo = m_lo; e.ret = m_ret; e.stl = m_stl;
        if (en_check) sb.push_back(e);
        acc = v && e.ready && !r;
        if (hd && !done) begin
            m_stl++;
            m_wait--;
        end
        if (commit) begin
            m_ret++;
            if (m_cur.hwe) begin
                case (m_cur.hsel)
                    2'd0: m_hi = m_cur.dr;
                    2'd1: m_hi = m_cur.mhi;
                    2'd2: m_hi = m_cur.rs;
                    default: ;
                endcase
            end
            if (m_cur.lwe) begin
                case (m_cur.lsel)
                    2'd0: m_lo = m_cur.dq;
                    2'd1: m_lo = m_cur.mlo;
                    2'd2: m_lo = m_cur.rs;
                    default: ;
                endcase
            end
        end
        if (fl) m_held = 1'b0;
        else if (acc) begin
            m_held = 1'b1; m_cur = ins; m_wait = ins.dwait;
        end else if (commit) m_held = 1'b0;
        if (r) model_reset();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) cycle(1'b0, rand_instr(1'b1), 1'b0, 1'b0, a);
    endtask

    task automatic issue(input instr_t ins);
        bit a;
        cycle(1'b1, ins, 1'b0, 1'b0, a);
        if (!a) begin
            n_checks++;
            $display("FAIL issue: directed instruction not accepted (ready 0 expected 1)");
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("in_ready",   32'(in_ready),  32'(e.ready));
                chk("div_abort",  32'(div_abort), 32'(e.abort));
                chk("rf_we",      32'(rf_we),     32'(e.we));
                chk("rf_waddr",   32'(rf_waddr),  32'(e.waddr));
                chk("rf_wdata",   rf_wdata,       e.wdata);
                chk("hi_q",       hi_q,           e.hi);
                chk("lo_q",       lo_q,           e.lo);
                chk("retire_cnt", retire_cnt,     e.ret);
                chk("stall_cnt",  stall_cnt,      e.stl);
            end
        end
    end

    initial begin
        instr_t i, pend;
        bit     a, have_pend;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        npc = '0; rs_data = '0; cp0_data = '0; alu_data = '0; clz_data = '0;
        mul_hi = '0; mul_lo = '0; dmem_data = '0; rd_sel = '0; rd_waddr = '0;
        rd_wena = 1'b0; hi_sel = '0; lo_sel = '0; hi_wena = 1'b0; lo_wena = 1'b0;
        div_r = '0; div_q = '0; div_done = 1'b0;
        model_reset();
        cycle(1'b0, zero_instr(), 1'b0, 1'b1, a);
        cycle(1'b0, zero_instr(), 1'b0, 1'b1, a);
        en_check = 1'b1;
        idle(1);

        // ALU write to r8
        i = zero_instr(); i.rd_sel = 3'd5; i.alu = 32'h1234; i.waddr = 5'd8;
        i.wena = 1'b1; i.hsel = 2'd3; i.lsel = 2'd3;
        issue(i);
        // write to $0: no rf_we but still retires
        i.waddr = 5'd0;
        issue(i);
        idle(1);

        // DIV: 3 cycles of waiting, then q=7 r=2
        i = zero_instr(); i.hwe = 1'b1; i.lwe = 1'b1; i.hsel = 2'd0; i.lsel = 2'd0;
        i.dwait = 3; i.dq = 32'd7; i.dr = 32'd2;
        issue(i);
        for (int k = 0; k < 4; k++) cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0, a);
        idle(2);

        // MTHI 0xDEAD then MFHI into r9, back to back
        i = zero_instr(); i.hwe = 1'b1; i.hsel = 2'd2; i.lsel = 2'd3; i.rs = 32'hDEAD;
        issue(i);
        i = zero_instr(); i.rd_sel = 3'd6; i.waddr = 5'd9; i.wena = 1'b1;
        i.hsel = 2'd3; i.lsel = 2'd3;
        issue(i);
        idle(1);

        // Flush during divide wait
        i = zero_instr(); i.hwe = 1'b1; i.lwe = 1'b1; i.dwait = 4;
        i.dq = 32'h1111; i.dr = 32'h2222;
        issue(i);
        idle(2);
        cycle(1'b1, rand_instr(1'b1), 1'b1, 1'b0, a);
        idle(2);

        // Ten back-to-back non-divide instructions
        for (int k = 0; k < 10; k++) issue(rand_instr(1'b0));
        idle(2);

        // Randomized traffic, valid held until accepted, with one reset
        have_pend = 1'b0;
        pend = zero_instr();
        for (int c = 0; c < 3000; c++) begin
            bit v, fl, r;
            if (!have_pend && $urandom_range(0, 3) != 0) begin
                pend = rand_instr(1'b1); have_pend = 1'b1;
            end
            v  = have_pend;
            fl = ($urandom_range(0, 24) == 0);
            r  = (c == 1500);
            cycle(v, pend, fl, r, a);
            if (a || fl || r) have_pend = 1'b0;
        end
        idle(8);

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
